key_cond_1596: RTL
==================

# key_cond_1596

Input conditioning stage for the door controller. Takes the raw, asynchronous push-button and limit-sensor signals, synchronises them into the clk2m domain and debounces them, then delivers clean active-high levels on key_up, key_down, sense_up and sense_down to the door state machine. Every channel is handled identically by a per-channel debounce FSM, so bounces shorter than the debounce window never reach the door logic.

## Interface
- DEBOUNCE_CYC, 20000: consecutive clk2m cycles a new level must hold before it is accepted (20000 = 10 ms at 2 MHz); legal range ≥ 2
- SYNC_STAGES, 2: synchroniser flop depth per channel; legal range ≥ 2
- Reset is rst_n, asynchronous, active-low. The clock is clk2m.
- rst_n  input  1  asynchronous active-low reset
- clk2m  input  1  2 MHz system clock
- key_up_n  input  1  raw "open" button, active-low (pull-up)
- key_down_n  input  1  raw "close" button, active-low (pull-up)
- sense_up_raw  input  1  raw upper limit switch, active-high
- sense_down_raw  input  1  raw lower limit switch, active-high
- key_up  output  1  debounced "open" button, active-high
- key_down  output  1  debounced "close" button, active-high
- sense_up  output  1  debounced upper limit, active-high
- sense_down  output  1  debounced lower limit, active-high
- key_up_pulse  output  1  one-cycle pulse on key_up rising edge (only with KEY_COND_PULSE_EN)
- key_down_pulse  output  1  one-cycle pulse on key_down rising edge (only with KEY_COND_PULSE_EN)

## Operation
- Polarity: the key inputs are inverted at the pin, before the synchroniser. Internally every channel is active-high.
- Synchroniser: a chain of SYNC_STAGES flops per channel. All stages reset to 0 (the inactive level). The last stage output is the sample s.
- Per-channel FSM, two states. Each channel has a registered output out and a counter cnt of width $clog2(DEBOUNCE_CYC).
  - STABLE: cnt = 0. If s ≠ out, go to CHECK with cnt = 1. Otherwise stay in STABLE.
  - CHECK: if s = out (bounce), clear cnt and return to STABLE; out is unchanged. Else if cnt = DEBOUNCE_CYC−1, toggle out, clear cnt and go to STABLE. Else increment cnt.
- The counter never wraps. The terminal compare fires before overflow.
- Channels are fully independent. Simultaneous activity on several channels, including key_up and key_down together, is passed through unchanged. Any arbitration between the two keys is the door FSM's job.
- Reset values: all outputs 0, all FSMs in STABLE, all counters 0, all synchroniser flops 0.
- If rst_n is asserted mid-debounce, the pending change is discarded. After release, a level that is still present must be qualified again with the full latency.
- Illegal FSM encoding: recover to STABLE with cnt = 0.

## Timing
- Latency from the first clk2m edge that captures a new raw level to the output change is SYNC_STAGES + DEBOUNCE_CYC − 1 edges. The raw level must stay constant throughout.
- A glitch or bounce shorter than DEBOUNCE_CYC − 1 cycles (after synchronisation) produces no output change.
- Assertion and release have identical latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- KEY_COND_PULSE_EN defined:
  - key_up_pulse and key_down_pulse ports exist.
  - Each port is high for exactly one cycle, in the cycle where the corresponding output goes 0→1. It is registered and aligned with the level output.
  - There is no pulse on release. Both pulses reset to 0.
- KEY_COND_PULSE_EN undefined:
  - The pulse ports and their edge-detect logic are absent.
  - The level outputs behave identically in both builds.

## Structure
- key_cond_pkg holds:
  - the debounce state enum (STABLE, CHECK), typed logic [0:0]
  - the default constants DEBOUNCE_CYC_DEF = 20000 and SYNC_STAGES_DEF = 2
- Sub-module debounce_ch: one synchroniser plus one debounce FSM plus its counter, parameterised by DEBOUNCE_CYC and SYNC_STAGES. The top level instantiates it four times. The top also contains the key inversion and the optional pulse logic.

## Test plan
All scenarios use DEBOUNCE_CYC = 4 and SYNC_STAGES = 2.
- Reset: hold rst_n = 0 with key_up_n = 0 and sense_up_raw = 1 → all outputs are 0 during reset. After release, key_up and sense_up go 1 exactly 5 edges after the first capturing edge.
- Clean press: key_down_n 1→0, held for 20 cycles → key_down rises after 5 edges. Releasing it (0→1) → key_down falls after 5 edges.
- Bounce: sense_down_raw toggles 1,0,1,0 with each level held 2 cycles, then stays 1 → sense_down stays 0 during the bounce and rises 5 edges after the final stable 1 is captured.
- Simultaneous keys: key_up_n and key_down_n both drop on the same cycle → key_up and key_down rise on the same cycle, while sense_up and sense_down are unaffected.
- Reset mid-debounce: key_up_n low for 3 cycles, then a 1-cycle rst_n pulse, then key_up_n still low → key_up rises only after a full 5-edge qualification that starts after reset release.
- Pulse (KEY_COND_PULSE_EN defined): press and then release key_up → key_up_pulse is exactly 1 cycle high, coincident with the key_up rising edge, with no pulse on release. With the macro undefined, the build succeeds without the pulse ports.

Source files
------------

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and defaults for the door-controller input conditioning stage.
//   db_state_t      : per-channel debounce FSM state (STABLE, CHECK)
//   DEBOUNCE_CYC_DEF: default debounce window in clk2m cycles (10 ms at 2 MHz)
//   SYNC_STAGES_DEF : default synchroniser depth
package key_cond_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } db_state_t;

    localparam int DEBOUNCE_CYC_DEF = 20000;
    localparam int SYNC_STAGES_DEF  = 2;

endpackage

// File: rtl/key_cond_1596_debounce_ch.sv
// debounce_ch: one channel of synchroniser plus debounce FSM.
//   clk2m    in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   din      in  : raw active-high level (asynchronous)
//   dout     out : debounced, registered level
//   dout_nxt out : value dout takes at the next edge (lets the top build an
//                  edge pulse that lands in the same cycle as the level change)
module debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic dout_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    db_state_t              state;
    logic                   s;

    assign s        = sync[SYNC_STAGES-1];
    assign dout_nxt = dout ^ (state == CHECK && s != dout && cnt == TERM);

    always_ff @(posedge clk2m or negedge rst_n)
        if (!rst_n)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], din};

    // cnt counts consecutive cycles the sample has differed from dout;
    // it stops at TERM so it can never wrap.
    always_ff @(posedge clk2m or negedge rst_n)
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            case (state)
                STABLE:
                    if (s != dout) begin
                        state <= CHECK;
                        cnt   <= CW'(1);
                    end else
                        cnt <= '0;
                CHECK:
                    if (s == dout) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TERM) begin
                        state <= STABLE;
                        cnt   <= '0;
                        dout  <= ~dout;
                    end else
                        cnt <= cnt + 1'b1;
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end

endmodule

// File: rtl/key_cond_1596.sv
// key_cond_1596: synchronises and debounces the door buttons and limit sensors.
//   rst_n          in  : asynchronous active-low reset
//   clk2m          in  : 2 MHz system clock
//   key_up_n       in  : raw "open" button, active-low
//   key_down_n     in  : raw "close" button, active-low
//   sense_up_raw   in  : raw upper limit switch, active-high
//   sense_down_raw in  : raw lower limit switch, active-high
//   key_up/key_down/sense_up/sense_down out : debounced active-high levels
//   key_up_pulse/key_down_pulse out : one-cycle press pulses, present only
//                    when KEY_COND_PULSE_EN is defined
module key_cond_1596
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic rst_n,
    input  logic clk2m,
    input  logic key_up_n,
    input  logic key_down_n,
    input  logic sense_up_raw,
    input  logic sense_down_raw,
    output logic key_up,
    output logic key_down,
    output logic sense_up,
    output logic sense_down
`ifdef KEY_COND_PULSE_EN
    ,
    output logic key_up_pulse,
    output logic key_down_pulse
`endif
);

    // Keys are inverted at the pin so that the synchroniser's reset value
    // of 0 means "not pressed" on every channel.
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] nxt;

    assign raw = {sense_down_raw, sense_up_raw, ~key_down_n, ~key_up_n};
    assign {sense_down, sense_up, key_down, key_up} = lvl;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk2m   (clk2m),
            .rst_n   (rst_n),
            .din     (raw[i]),
            .dout    (lvl[i]),
            .dout_nxt(nxt[i])
        );
    end

`ifdef KEY_COND_PULSE_EN
    logic unused_nxt;
    assign unused_nxt = ^nxt[3:2];

    // Registered from the next level so the pulse coincides with the rising level.
    always_ff @(posedge clk2m or negedge rst_n)
        if (!rst_n) begin
            key_up_pulse   <= 1'b0;
            key_down_pulse <= 1'b0;
        end else begin
            key_up_pulse   <= nxt[0] & ~lvl[0];
            key_down_pulse <= nxt[1] & ~lvl[1];
        end
`else
    logic unused_nxt;
    assign unused_nxt = ^nxt;
`endif

endmodule
